// File: rtl/proc_defs.sv
// Shared encodings for the microcoded processor: bus select codes, ALU ops,
// opcodes and the control FSM state type.
package proc_defs;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_JFETCH  = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [3:0] BUS_NONE = 4'b0000;
  localparam logic [3:0] BUS_MDR  = 4'b0001;
  localparam logic [3:0] BUS_PC   = 4'b0010;
  localparam logic [3:0] BUS_MBRU = 4'b0011;
  localparam logic [3:0] BUS_L    = 4'b0100;
  localparam logic [3:0] BUS_C1   = 4'b0101;
  localparam logic [3:0] BUS_C2   = 4'b0110;
  localparam logic [3:0] BUS_C3   = 4'b0111;
  localparam logic [3:0] BUS_T    = 4'b1000;
  localparam logic [3:0] BUS_E    = 4'b1001;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SHR1 = 3'b100;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SHR  = 4'h4;
  localparam logic [3:0] OP_WR   = 4'h5;
  localparam logic [3:0] OP_LDM  = 4'h6;
  localparam logic [3:0] OP_STM  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // MDR, MBRU and the unassigned codes are not writable register destinations.
  function automatic logic wr_dest_ok(input logic [3:0] r);
    return r inside {BUS_PC, BUS_L, BUS_C1, BUS_C2, BUS_C3, BUS_T, BUS_E};
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Control FSM: fetches an 8-bit instruction, decodes it and drives the bus,
// ALU, memory and PC strobes. State is exposed on state_dbg.
module control_unit
  import proc_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       iram_ready,
  input  logic       dmem_ready,
  input  logic       z_flag,
  output logic       iram_rd,
  output logic       dmem_rd,
  output logic       dmem_wr,
  output logic [3:0] B_Bus_ctrl,
  output logic [3:0] C_Bus_ctrl,
  output logic [2:0] alu_op,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] jmp_addr,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  // Handshake: a request (iram_rd, dmem_rd, dmem_wr) stays high until the
  // matching ready is seen in the same cycle; that cycle completes the access.
  // A ready arriving in any state not waiting on it has no effect.

  state_t     state;
  logic [7:0] ir;
  logic [3:0] op;
  logic [3:0] r;

  assign op        = ir[7:4];
  assign r         = ir[3:0];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= 8'h00;
      jmp_addr <= 8'h00;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_FETCH;
        S_FETCH: begin
          if (iram_ready) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == OP_JMP)       state <= S_JFETCH;
          else if (op == OP_HALT) state <= S_HALT;
          else                    state <= S_EXEC;
        end
        S_EXEC: begin
          if (op_illegal(op) || (op == OP_WR && !wr_dest_ok(r))) err <= 1'b1;
          if (op == OP_LDM || op == OP_STM) state <= S_MEMWAIT;
          else                              state <= S_FETCH;
        end
        S_MEMWAIT: if (dmem_ready) state <= S_FETCH;
        S_JFETCH: begin
          if (iram_ready) begin
            jmp_addr <= instr;
            state    <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state and IR so that reset clears them without a clock.
  always_comb begin
    iram_rd    = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    B_Bus_ctrl = BUS_NONE;
    C_Bus_ctrl = BUS_NONE;
    alu_op     = ALU_NONE;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    done       = 1'b0;
    case (state)
      S_FETCH: begin
        iram_rd = 1'b1;
        pc_inc  = iram_ready;
      end
      S_EXEC: begin
        case (op)
          OP_MOV: begin
            B_Bus_ctrl = r;
            alu_op     = ALU_PASS;
            C_Bus_ctrl = BUS_C3;
          end
          OP_ADD: begin
            B_Bus_ctrl = r;
            alu_op     = ALU_ADD;
            C_Bus_ctrl = BUS_C3;
          end
          OP_SUB: begin
            B_Bus_ctrl = r;
            alu_op     = ALU_SUB;
            C_Bus_ctrl = BUS_C3;
          end
          OP_SHR: begin
            B_Bus_ctrl = r;
            alu_op     = ALU_SHR1;
            C_Bus_ctrl = BUS_C3;
          end
          OP_WR: begin
            B_Bus_ctrl = BUS_C3;
            alu_op     = ALU_PASS;
            C_Bus_ctrl = wr_dest_ok(r) ? r : BUS_NONE;
          end
          OP_LDM: dmem_rd = 1'b1;
          OP_STM: dmem_wr = 1'b1;
          default: ;
        endcase
      end
      S_MEMWAIT: begin
        dmem_rd = (op == OP_LDM);
        dmem_wr = (op == OP_STM);
        if (op == OP_LDM && dmem_ready) C_Bus_ctrl = BUS_MDR;
      end
      S_JFETCH: begin
        iram_rd = 1'b1;
        if (iram_ready) begin
          pc_load = z_flag;
          pc_inc  = ~z_flag;
        end
      end
      S_HALT: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: drives instruction and memory traffic and
// checks each cycle against a per-instruction reference model.
module tb_control_unit;
  import proc_defs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       iram_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       z_flag = 1'b0;
  logic       iram_rd, dmem_rd, dmem_wr;
  logic [3:0] B_Bus_ctrl, C_Bus_ctrl;
  logic [2:0] alu_op;
  logic       pc_inc, pc_load, done, err;
  logic [7:0] jmp_addr;
  logic [2:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];
  logic exp_err = 1'b0;
  int pinc, pload, mcyc, mdr;

  wire [16:0] ctrl_bus = {iram_rd, dmem_rd, dmem_wr, B_Bus_ctrl, C_Bus_ctrl,
                          alu_op, pc_inc, pc_load, done};

  control_unit dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr),
    .iram_ready(iram_ready), .dmem_ready(dmem_ready), .z_flag(z_flag),
    .iram_rd(iram_rd), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .B_Bus_ctrl(B_Bus_ctrl), .C_Bus_ctrl(C_Bus_ctrl), .alu_op(alu_op),
    .pc_inc(pc_inc), .pc_load(pc_load), .jmp_addr(jmp_addr),
    .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      vectors++;
      if (pc_inc === 1'b1 && pc_load === 1'b1) begin
        miscompares++;
        $display("FAIL pc_exclusive: pc_inc=%b pc_load=%b, required not both 1", pc_inc, pc_load);
      end
    end
  end

  // Reference: what one EXEC cycle must show, {err_set, B, alu, C}.
  function automatic logic [11:0] exec_model(input logic [7:0] b);
    logic [3:0] op, r;
    op = b[7:4];
    r  = b[3:0];
    case (op)
      4'h1: return {1'b0, r, 3'b001, 4'b0111};
      4'h2: return {1'b0, r, 3'b010, 4'b0111};
      4'h3: return {1'b0, r, 3'b011, 4'b0111};
      4'h4: return {1'b0, r, 3'b100, 4'b0111};
      4'h5: begin
        if (r inside {4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9})
          return {1'b0, 4'b0111, 3'b001, r};
        else
          return {1'b1, 4'b0111, 3'b001, 4'b0000};
      end
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: return {1'b1, 11'b0};
      default: return 12'b0;
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if (state_dbg !== S_IDLE || ctrl_bus !== 17'h0) begin
      miscompares++;
      $display("FAIL start_idle: state=%0d ctrl=%h, required state=%0d ctrl=0", state_dbg, ctrl_bus, S_IDLE);
    end
    step;
    start = 1'b0;
  endtask

  // Drives one instruction from the FETCH state through to the next FETCH.
  task automatic run_instr(input logic [7:0] b, input int ilat, input int dlat,
                           input logic [7:0] jb, input logic z,
                           output int n_inc, output int n_load,
                           output int n_mem, output int n_mdr);
    logic [3:0] op;
    logic [11:0] w;
    logic exp_rd, exp_wr;
    op = b[7:4];
    n_inc = 0; n_load = 0; n_mem = 0; n_mdr = 0;
    exp_rd = (op == 4'h6);
    exp_wr = (op == 4'h7);
    if (op != 4'h8 && op != 4'hF) exp_q.push_back(exec_model(b));
    for (int i = 0; i < ilat; i++) begin
      iram_ready = 1'b0; instr = 8'($urandom); dmem_ready = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (state_dbg !== S_FETCH || iram_rd !== 1'b1 || pc_inc !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_wait: state=%0d iram_rd=%b pc_inc=%b, required state=%0d 1 0", state_dbg, iram_rd, pc_inc, S_FETCH);
      end
      step;
    end
    instr = b; iram_ready = 1'b1; dmem_ready = 1'($urandom);
    @(negedge clk);
    n_inc += int'(pc_inc); n_load += int'(pc_load);
    vectors++;
    if (state_dbg !== S_FETCH || iram_rd !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_ready: state=%0d iram_rd=%b pc_inc=%b pc_load=%b, required state=%0d 1 1 0", state_dbg, iram_rd, pc_inc, pc_load, S_FETCH);
    end
    step;
    iram_ready = 1'($urandom); instr = 8'($urandom); dmem_ready = 1'($urandom);
    @(negedge clk);
    vectors++;
    if (state_dbg !== S_DECODE || ctrl_bus !== 17'h0) begin
      miscompares++;
      $display("FAIL decode: state=%0d ctrl=%h, required state=%0d ctrl=0", state_dbg, ctrl_bus, S_DECODE);
    end
    step;
    iram_ready = 1'b0; dmem_ready = 1'b0;
    if (op == 4'hF) begin
      @(negedge clk);
      vectors++;
      if (state_dbg !== S_HALT || ctrl_bus !== 17'h1) begin
        miscompares++;
        $display("FAIL halt_enter: state=%0d ctrl=%h, required state=%0d ctrl=1", state_dbg, ctrl_bus, S_HALT);
      end
      step;
    end else if (op == 4'h8) begin
      for (int i = 0; i < ilat; i++) begin
        iram_ready = 1'b0; instr = 8'($urandom); z_flag = 1'($urandom); dmem_ready = 1'($urandom);
        @(negedge clk);
        vectors++;
        if (state_dbg !== S_JFETCH || iram_rd !== 1'b1 || pc_inc !== 1'b0 || pc_load !== 1'b0) begin
          miscompares++;
          $display("FAIL jfetch_wait: state=%0d iram_rd=%b pc_inc=%b pc_load=%b, required state=%0d 1 0 0", state_dbg, iram_rd, pc_inc, pc_load, S_JFETCH);
        end
        step;
      end
      instr = jb; iram_ready = 1'b1; z_flag = z; dmem_ready = 1'b0;
      @(negedge clk);
      n_inc += int'(pc_inc); n_load += int'(pc_load);
      vectors++;
      if (state_dbg !== S_JFETCH || iram_rd !== 1'b1 || pc_load !== z || pc_inc !== !z) begin
        miscompares++;
        $display("FAIL jfetch_ready: state=%0d pc_load=%b pc_inc=%b, required state=%0d pc_load=%b pc_inc=%b", state_dbg, pc_load, pc_inc, S_JFETCH, z, !z);
      end
      step;
      iram_ready = 1'b0;
      vectors++;
      if (jmp_addr !== jb) begin
        miscompares++;
        $display("FAIL jmp_addr: got %h, required %h", jmp_addr, jb);
      end
    end else begin
      w = exp_q.pop_front();
      iram_ready = 1'($urandom);
      @(negedge clk);
      n_inc += int'(pc_inc); n_load += int'(pc_load);
      n_mem += int'(dmem_rd | dmem_wr); n_mdr += int'(C_Bus_ctrl == 4'b0001);
      vectors++;
      if (state_dbg !== S_EXEC || {B_Bus_ctrl, alu_op, C_Bus_ctrl} !== w[10:0] ||
          dmem_rd !== exp_rd || dmem_wr !== exp_wr || iram_rd !== 1'b0 || pc_inc !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL exec_%h: state=%0d B/alu/C=%h rd=%b wr=%b, required state=%0d B/alu/C=%h rd=%b wr=%b",
                 b, state_dbg, {B_Bus_ctrl, alu_op, C_Bus_ctrl}, dmem_rd, dmem_wr, S_EXEC, w[10:0], exp_rd, exp_wr);
      end
      step;
      iram_ready = 1'b0;
      exp_err = exp_err | w[11];
      vectors++;
      if (err !== exp_err) begin
        miscompares++;
        $display("FAIL err_after_%h: got %b, required %b", b, err, exp_err);
      end
      if (op == 4'h6 || op == 4'h7) begin
        for (int i = 0; i <= dlat; i++) begin
          dmem_ready = (i == dlat); iram_ready = 1'($urandom);
          @(negedge clk);
          n_mem += int'(dmem_rd | dmem_wr); n_mdr += int'(C_Bus_ctrl == 4'b0001);
          vectors++;
          if (state_dbg !== S_MEMWAIT || dmem_rd !== exp_rd || dmem_wr !== exp_wr || iram_rd !== 1'b0 ||
              C_Bus_ctrl !== ((exp_rd && i == dlat) ? 4'b0001 : 4'b0000)) begin
            miscompares++;
            $display("FAIL memwait: state=%0d rd=%b wr=%b C=%b, required state=%0d rd=%b wr=%b", state_dbg, dmem_rd, dmem_wr, C_Bus_ctrl, S_MEMWAIT, exp_rd, exp_wr);
          end
          step;
        end
        dmem_ready = 1'b0; iram_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; iram_ready = 1'b0; dmem_ready = 1'b0; z_flag = 1'b0; instr = 8'h00;
    #3;
    vectors++;
    if (state_dbg !== S_IDLE || ctrl_bus !== 17'h0 || err !== 1'b0 || jmp_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d ctrl=%h err=%b jmp=%h, required all 0", state_dbg, ctrl_bus, err, jmp_addr);
    end
    step; step;
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (state_dbg !== S_IDLE || ctrl_bus !== 17'h0) begin
        miscompares++;
        $display("FAIL idle_hold: state=%0d ctrl=%h, required state=%0d ctrl=0", state_dbg, ctrl_bus, S_IDLE);
      end
      step;
    end
  endtask

  task automatic test_nop;
    do_start;
    run_instr(8'h00, 0, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    vectors++;
    if (pinc !== 1 || pload !== 0) begin
      miscompares++;
      $display("FAIL nop_pc: pc_inc pulses=%0d pc_load pulses=%0d, required 1 0", pinc, pload);
    end
  endtask

  task automatic test_alu_ops;
    run_instr(8'h25, 1, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    for (int i = 0; i < 14; i++)
      run_instr({4'($urandom_range(0, 5)), 4'($urandom)}, $urandom_range(0, 3), 0, 8'h00, 1'b0,
                pinc, pload, mcyc, mdr);
  endtask

  task automatic test_mem;
    int lat;
    run_instr(8'h60, 0, 2, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    vectors++;
    if (mcyc !== 4 || mdr !== 1) begin
      miscompares++;
      $display("FAIL ldm_cycles: dmem_rd cycles=%0d MDR cycles=%0d, required 4 1", mcyc, mdr);
    end
    for (int i = 0; i < 4; i++) begin
      lat = $urandom_range(0, 4);
      run_instr({4'h7, 4'($urandom)}, $urandom_range(0, 2), lat, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
      vectors++;
      if (mcyc !== lat + 2 || mdr !== 0) begin
        miscompares++;
        $display("FAIL stm_cycles: dmem_wr cycles=%0d MDR cycles=%0d, required %0d 0", mcyc, mdr, lat + 2);
      end
    end
  endtask

  task automatic test_jump;
    logic zz;
    run_instr(8'h80, 0, 0, 8'h3C, 1'b1, pinc, pload, mcyc, mdr);
    vectors++;
    if (pinc !== 1 || pload !== 1) begin
      miscompares++;
      $display("FAIL jump_taken: pc_inc=%0d pc_load=%0d, required 1 1", pinc, pload);
    end
    run_instr(8'h80, 0, 0, 8'h3C, 1'b0, pinc, pload, mcyc, mdr);
    vectors++;
    if (pinc !== 2 || pload !== 0) begin
      miscompares++;
      $display("FAIL jump_not_taken: pc_inc=%0d pc_load=%0d, required 2 0", pinc, pload);
    end
    for (int i = 0; i < 4; i++) begin
      zz = 1'($urandom);
      run_instr({4'h8, 4'($urandom)}, $urandom_range(0, 3), 0, 8'($urandom), zz, pinc, pload, mcyc, mdr);
      vectors++;
      if (pload !== int'(zz) || pinc !== 2 - int'(zz)) begin
        miscompares++;
        $display("FAIL jump_rand: pc_inc=%0d pc_load=%0d, required %0d %0d", pinc, pload, 2 - int'(zz), int'(zz));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom),
                1'($urandom), pinc, pload, mcyc, mdr);
    end
  endtask

  task automatic test_err;
    test_reset;
    do_start;
    run_instr(8'h53, 0, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_mbru_err: got %b, required 1", err);
    end
    run_instr(8'hA0, 2, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    run_instr(8'h25, 0, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
  endtask

  task automatic test_reset_memwait;
    instr = 8'h70; iram_ready = 1'b1;
    step;
    iram_ready = 1'b0;
    step;
    step;
    @(negedge clk);
    vectors++;
    if (state_dbg !== S_MEMWAIT || dmem_wr !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL stm_wait: state=%0d dmem_wr=%b err=%b, required state=%0d 1 1", state_dbg, dmem_wr, err, S_MEMWAIT);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (state_dbg !== S_IDLE || dmem_wr !== 1'b0 || err !== 1'b0 || ctrl_bus !== 17'h0) begin
      miscompares++;
      $display("FAIL async_reset: state=%0d dmem_wr=%b err=%b ctrl=%h, required IDLE 0 0 0", state_dbg, dmem_wr, err, ctrl_bus);
    end
    step;
    rst = 1'b0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_halt;
    do_start;
    run_instr(8'hF0, 1, 0, 8'h00, 1'b0, pinc, pload, mcyc, mdr);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; iram_ready = 1'($urandom); dmem_ready = 1'($urandom); instr = 8'($urandom);
      @(negedge clk);
      vectors++;
      if (state_dbg !== S_HALT || ctrl_bus !== 17'h1) begin
        miscompares++;
        $display("FAIL halt_hold: state=%0d ctrl=%h, required state=%0d ctrl=1", state_dbg, ctrl_bus, S_HALT);
      end
      step;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nop;
    test_alu_ops;
    test_mem;
    test_jump;
    test_back_to_back;
    test_err;
    test_reset_memwait;
    test_halt;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  begins program execution from IDLE.
REQ-004 SHALL have ports: instr  input  8  instruction-memory read data; iram_ready  input  1  instruction-memory data valid.
REQ-005 SHALL have ports: dmem_ready  input  1  data-memory access complete; z_flag  input  1  ALU zero flag.
REQ-006 SHALL have ports: iram_rd  output  1  instruction read request; dmem_rd  output  1; dmem_wr  output  1.
REQ-007 SHALL have ports: B_Bus_ctrl  output  4  B-bus source select; C_Bus_ctrl  output  4  C-bus destination select, same codes, 0000 = none.
REQ-008 SHALL have ports: alu_op  output  3  ALU operation (000 none, 001 pass, 010 add, 011 sub, 100 shr1).
REQ-009 SHALL have ports: pc_inc  output  1; pc_load  output  1; jmp_addr  output  8; done  output  1; err  output  1 (sticky).

Function
REQ-010 B/C select codes SHALL be: 0001 MDR, 0010 PC, 0011 MBRU, 0100 L, 0101 C1, 0110 C2, 0111 C3, 1000 T, 1001 E, others = none.
REQ-011 Instruction format SHALL be op = instr[7:4], r = instr[3:0].
REQ-012 States SHALL be IDLE, FETCH, DECODE, EXEC, MEMWAIT, JFETCH, HALT.
REQ-013 IDLE -> FETCH on start=1; otherwise remain in IDLE.
REQ-014 FETCH: iram_rd=1 every cycle until iram_ready=1; in that cycle capture instr into internal IR, pulse pc_inc, go to DECODE.
REQ-015 DECODE SHALL last exactly 1 cycle with all control outputs inactive, then go to EXEC (op 0x8 -> JFETCH, op 0xF -> HALT).
REQ-016 EXEC outputs SHALL be combinational from state and IR, held 1 cycle, then FETCH:
- 0x0 NOP: nothing.
- 0x1 MOV: B_Bus_ctrl=r, alu_op=001, C_Bus_ctrl=0111 (C3 accumulator).
- 0x2 ADD / 0x3 SUB: B_Bus_ctrl=r, alu_op=010/011, C_Bus_ctrl=0111.
- 0x4 SHR: B_Bus_ctrl=r, alu_op=100, C_Bus_ctrl=0111.
- 0x5 WR: B_Bus_ctrl=0111, alu_op=001, C_Bus_ctrl=r.
REQ-017 Ops 0x6 LDM / 0x7 STM SHALL go EXEC -> MEMWAIT, holding dmem_rd / dmem_wr = 1 until dmem_ready=1, then go to FETCH; LDM asserts C_Bus_ctrl=0001 in the ready cycle.
REQ-018 JFETCH: iram_rd=1 until iram_ready; in the ready cycle register instr into jmp_addr; if z_flag=1 pulse pc_load, else pulse pc_inc; go to FETCH.
REQ-019 HALT: done=1, all other control outputs 0; start ignored; exit only by rst.
REQ-020 Opcodes 0x9-0xE SHALL execute as NOP and set err.
REQ-021 WR with r in {0000, 0001, 0011, 1010-1111} SHALL suppress C_Bus_ctrl (0000) and set err.
REQ-022 dmem_ready or iram_ready asserted in states not waiting for them SHALL be ignored.
REQ-023 pc_inc and pc_load SHALL never be asserted in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, IR=0, jmp_addr=0, err=0, and all outputs 0, including mid-memory-wait.
REQ-025 First rising edge after rst deasserts SHALL evaluate IDLE normally.

Structure
REQ-026 Bus select codes, alu_op codes, opcodes, and state encoding SHALL live in shared package/include proc_defs.
REQ-027 The controller SHALL be a single module with no sub-modules; EXEC output decode is one case statement.

Verification
REQ-028 Reset, start, NOP (instr 0x00, iram_ready immediate) -> FETCH 1, DECODE 1, EXEC 1 cycles; pc_inc exactly once.
REQ-029 instr 0x25 (ADD C1) -> EXEC cycle B_Bus_ctrl=0101, alu_op=010, C_Bus_ctrl=0111.
REQ-030 instr 0x60 (LDM), dmem_ready after 3 cycles -> dmem_rd high 4 cycles; C_Bus_ctrl=0001 only in the final cycle.
REQ-031 instr 0x80 then byte 0x3C: z_flag=1 -> jmp_addr=0x3C, pc_load pulse; z_flag=0 -> pc_inc pulse, no pc_load.
REQ-032 instr 0x53 (WR MBRU) and 0xA0 -> C_Bus_ctrl stays 0000, err=1 and stays set; instr 0xF0 -> done=1, start ignored.
REQ-033 rst pulse during MEMWAIT with dmem_wr=1 -> dmem_wr falls without a clock edge; state IDLE, err=0.
